// File: rtl/sqrt_sched_if.sv
// Request, core and response signals of the two-requester sqrt scheduler.
// Latency: none, wiring only. Backpressure: rsp_valid/rsp_ready on the response side.
// The slave modport is the scheduler's view; the master modport is the environment's view.
interface sqrt_sched_if #(
    parameter int OPW = 16
);
    logic [1:0]       req;
    logic [OPW-1:0]   op0;
    logic [OPW-1:0]   op1;
    logic             core_start;
    logic [OPW-1:0]   core_op;
    logic             core_done;
    logic [OPW/2-1:0] core_root;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [OPW/2-1:0] rsp_root;
    logic             rsp_err;
    logic             busy;

    modport slave (
        input  req, op0, op1, core_done, core_root, rsp_ready,
        output core_start, core_op, rsp_valid, rsp_id, rsp_root, rsp_err, busy
    );

    modport master (
        output req, op0, op1, core_done, core_root, rsp_ready,
        input  core_start, core_op, rsp_valid, rsp_id, rsp_root, rsp_err, busy
    );
endinterface

// File: rtl/sqrt_sched.sv
// Round-robin scheduler sharing one sqrt core between two requesters; SQRT_SCHED_TIMEOUT_EN adds a RUN watchdog.
// Latency: grant -> core_start 1 cycle, core_done -> rsp_valid 1 cycle.
// Backpressure: response held in HOLD until rsp_ready; requests wait while busy.
module sqrt_sched #(
    parameter int OPW = 16,
    parameter int TMO = 63
) (
    input  logic        clk,
    input  logic        reset,
    sqrt_sched_if.slave bus
);
    localparam int RW = OPW / 2;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

    state_t         state_q, state_d;
    logic           core_start_q, core_start_d;
    logic [OPW-1:0] core_op_q, core_op_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic [RW-1:0]  rsp_root_q, rsp_root_d;
    logic           busy_q, busy_d;
    logic           prio_q, prio_d;
    logic           gnt_id;
    logic           tmo_hit;

`ifdef SQRT_SCHED_TIMEOUT_EN
    logic [5:0] cnt_q, cnt_d;
    logic       rsp_err_q, rsp_err_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == LOAD) begin
            cnt_d = '0;
        end else if (state_q == RUN && !bus.core_done) begin
            cnt_d = cnt_q + 6'd1;
        end
        // Fires on the RUN cycle whose increment reaches the limit.
        tmo_hit   = (state_q == RUN) && !bus.core_done && (cnt_d == 6'(TMO));
        rsp_err_d = rsp_err_q;
        if (state_q == RUN && bus.core_done) begin
            rsp_err_d = 1'b0;
        end else if (tmo_hit) begin
            rsp_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    logic unused_tmo;
    assign unused_tmo  = (TMO != 0);
    assign tmo_hit     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        core_start_d = 1'b0;
        core_op_d    = core_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_root_d   = rsp_root_q;
        prio_d       = prio_q;
        // Single requester wins outright; on a tie the favoured one wins.
        gnt_id       = bus.req[0] ? (bus.req[1] & prio_q) : 1'b1;
        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    state_d      = LOAD;
                    core_start_d = 1'b1;
                    rsp_id_d     = gnt_id;
                    core_op_d    = gnt_id ? bus.op1 : bus.op0;
                end
            end
            LOAD: state_d = RUN;
            RUN: begin
                if (bus.core_done) begin
                    state_d     = HOLD;
                    rsp_valid_d = 1'b1;
                    rsp_root_d  = bus.core_root;
                end else if (tmo_hit) begin
                    state_d     = HOLD;
                    rsp_valid_d = 1'b1;
                    rsp_root_d  = '0;
                end
            end
            HOLD: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    prio_d      = ~rsp_id_q;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            core_start_q <= 1'b0;
            core_op_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_root_q   <= '0;
            busy_q       <= 1'b0;
            prio_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_start_q <= core_start_d;
            core_op_q    <= core_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_root_q   <= rsp_root_d;
            busy_q       <= busy_d;
            prio_q       <= prio_d;
        end
    end

    assign bus.core_start = core_start_q;
    assign bus.core_op    = core_op_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_root   = rsp_root_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sqrt_sched.sv
// Bench for sqrt_sched: behavioural core responder, round-robin model and integer sqrt reference.
module tb_sqrt_sched;
    localparam int OPW = 16;
    localparam int RW  = OPW / 2;
    localparam int TMO = 63;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   last_served = -1;

    sqrt_sched_if #(.OPW(OPW)) bus ();
    sqrt_sched #(.OPW(OPW), .TMO(TMO)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    function automatic logic [RW-1:0] isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return RW'(r);
    endfunction

    function automatic int exp_winner(input logic [1:0] r);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return (last_served == 0) ? 1 : 0;
    endfunction

    task automatic reset_dut();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        last_served = -1;
    endtask

    // Waits for core_start, then answers with the true root after lat cycles.
    task automatic run_core(input int lat, output logic [OPW-1:0] op_seen, output int n_start, output bit to);
        int t = 0;
        n_start = 0;
        to      = 1'b0;
        op_seen = '0;
        while (bus.core_start !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            to = 1'b1;
            return;
        end
        op_seen = bus.core_op;
        n_start = 1;
        repeat (lat) begin
            @(negedge clk);
            if (bus.core_start === 1'b1) n_start++;
        end
        bus.core_done = 1'b1;
        bus.core_root = isqrt(int'(op_seen));
        @(negedge clk);
        bus.core_done = 1'b0;
        bus.core_root = '0;
    endtask

    task automatic accept();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.core_start, bus.rsp_valid, bus.rsp_err, bus.busy, bus.rsp_id, bus.rsp_root, bus.core_op} !== '0)
            begin errors++; $display("FAIL reset_outputs: got start=%b vld=%b err=%b busy=%b id=%b root=%0d op=%0d, want all 0",
                bus.core_start, bus.rsp_valid, bus.rsp_err, bus.busy, bus.rsp_id, bus.rsp_root, bus.core_op); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0)
            begin errors++; $display("FAIL reset_idle: busy=%b vld=%b, want 0 0", bus.busy, bus.rsp_valid); end
    endtask

    task automatic test_single();
        logic [OPW-1:0] op;
        int n;
        bit to;
        bus.op0 = 16'd144;
        bus.op1 = 16'($urandom);
        bus.req = 2'b01;
        @(negedge clk);
        checks++;
        if (bus.core_start !== 1'b1 || bus.core_op !== 16'd144 || bus.busy !== 1'b1)
            begin errors++; $display("FAIL single_grant: start=%b op=%0d busy=%b, want 1 144 1", bus.core_start, bus.core_op, bus.busy); end
        bus.req = 2'b00;
        run_core(10, op, n, to);
        checks++;
        if (to || n != 1)
            begin errors++; $display("FAIL single_start_pulses: got %0d (timeout=%0d), want 1", n, to); end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_root !== 8'd12 || bus.rsp_err !== 1'b0)
            begin errors++; $display("FAIL single_rsp: vld=%b id=%b root=%0d err=%b, want 1 0 12 0",
                bus.rsp_valid, bus.rsp_id, bus.rsp_root, bus.rsp_err); end
        accept();
        last_served = 0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL single_release: vld=%b busy=%b, want 0 0", bus.rsp_valid, bus.busy); end
    endtask

    task automatic test_round_robin();
        logic [OPW-1:0] op;
        int n, w;
        bit to;
        reset_dut();
        bus.op0 = 16'd81;
        bus.op1 = 16'd225;
        bus.req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            w = exp_winner(bus.req);
            run_core(int'($urandom_range(1, 6)), op, n, to);
            checks++;
            if (to || bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'(w) || bus.rsp_root !== isqrt(w == 1 ? 225 : 81))
                begin errors++; $display("FAIL rr_%0d: vld=%b id=%b root=%0d, want 1 %0d %0d",
                    i, bus.rsp_valid, bus.rsp_id, bus.rsp_root, w, isqrt(w == 1 ? 225 : 81)); end
            last_served = w;
            if (i == 2) bus.req = 2'b00;
            accept();
        end
    endtask

    task automatic test_hold_stable();
        logic [OPW-1:0] op, v;
        int n;
        bit to;
        v = 16'($urandom);
        bus.op1 = v;
        bus.req = 2'b10;
        run_core(int'($urandom_range(1, 8)), op, n, to);
        checks++;
        if (to || bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_root !== isqrt(int'(v)))
            begin errors++; $display("FAIL hold_first: vld=%b id=%b root=%0d, want 1 1 %0d",
                bus.rsp_valid, bus.rsp_id, bus.rsp_root, isqrt(int'(v))); end
        bus.req = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_root !== isqrt(int'(v)) || bus.core_start !== 1'b0 || bus.busy !== 1'b1)
                begin errors++; $display("FAIL hold_stable_%0d: vld=%b id=%b root=%0d start=%b busy=%b, want 1 1 %0d 0 1",
                    k, bus.rsp_valid, bus.rsp_id, bus.rsp_root, bus.core_start, bus.busy, isqrt(int'(v))); end
        end
        bus.req = 2'b00;
        accept();
        last_served = 1;
    endtask

    task automatic test_reset_mid_run();
        bus.op0 = 16'($urandom);
        bus.req = 2'b01;
        @(negedge clk);
        bus.req = 2'b00;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.core_start, bus.rsp_valid, bus.rsp_err, bus.busy, bus.rsp_id, bus.rsp_root, bus.core_op} !== '0)
            begin errors++; $display("FAIL midrun_reset_async: start=%b vld=%b err=%b busy=%b id=%b root=%0d op=%0d, want all 0",
                bus.core_start, bus.rsp_valid, bus.rsp_err, bus.busy, bus.rsp_id, bus.rsp_root, bus.core_op); end
        @(negedge clk);
        reset = 1'b1;
        last_served = -1;
        bus.core_done = 1'b1;
        bus.core_root = 8'h5a;
        @(negedge clk);
        bus.core_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.core_start !== 1'b0)
                begin errors++; $display("FAIL midrun_late_done_%0d: vld=%b busy=%b start=%b, want 0 0 0",
                    k, bus.rsp_valid, bus.busy, bus.core_start); end
        end
    endtask

    task automatic test_ignore_done();
        logic [OPW-1:0] v;
        bus.core_done = 1'b1;
        bus.core_root = 8'h77;
        @(negedge clk);
        bus.core_done = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL idle_done: vld=%b busy=%b, want 0 0", bus.rsp_valid, bus.busy); end
        v = 16'($urandom);
        bus.op0 = v;
        bus.req = 2'b01;
        @(negedge clk);
        checks++;
        if (bus.core_start !== 1'b1)
            begin errors++; $display("FAIL load_start: start=%b, want 1", bus.core_start); end
        bus.core_done = 1'b1;
        bus.req = 2'b00;
        @(negedge clk);
        bus.core_done = 1'b0;
        bus.core_root = '0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1)
                begin errors++; $display("FAIL load_done_%0d: vld=%b busy=%b, want 0 1", k, bus.rsp_valid, bus.busy); end
            @(negedge clk);
        end
        bus.core_done = 1'b1;
        bus.core_root = isqrt(int'(v));
        @(negedge clk);
        bus.core_done = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_root !== isqrt(int'(v)))
            begin errors++; $display("FAIL load_done_final: vld=%b id=%b root=%0d, want 1 0 %0d",
                bus.rsp_valid, bus.rsp_id, bus.rsp_root, isqrt(int'(v))); end
        accept();
        last_served = 0;
    endtask

    task automatic test_timeout();
        int n = 0;
        bus.op0 = 16'($urandom);
        bus.req = 2'b01;
        @(negedge clk);
        checks++;
        if (bus.core_start !== 1'b1)
            begin errors++; $display("FAIL tmo_start: start=%b, want 1", bus.core_start); end
        bus.req = 2'b00;
        @(negedge clk);
`ifdef SQRT_SCHED_TIMEOUT_EN
        while (bus.rsp_valid !== 1'b1 && n < TMO + 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != TMO || bus.rsp_err !== 1'b1 || bus.rsp_root !== '0 || bus.rsp_id !== 1'b0)
            begin errors++; $display("FAIL tmo_rsp: cycles=%0d err=%b root=%0d id=%b, want %0d 1 0 0",
                n, bus.rsp_err, bus.rsp_root, bus.rsp_id, TMO); end
`else
        repeat (100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1 || bus.rsp_err !== 1'b0)
            begin errors++; $display("FAIL no_tmo_wait: after %0d cycles vld=%b busy=%b err=%b, want 0 1 0",
                n, bus.rsp_valid, bus.busy, bus.rsp_err); end
        bus.core_done = 1'b1;
        bus.core_root = 8'd3;
        @(negedge clk);
        bus.core_done = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_root !== 8'd3 || bus.rsp_err !== 1'b0)
            begin errors++; $display("FAIL no_tmo_done: vld=%b root=%0d err=%b, want 1 3 0",
                bus.rsp_valid, bus.rsp_root, bus.rsp_err); end
`endif
        accept();
        last_served = 0;
    endtask

    task automatic test_random();
        logic [OPW-1:0] a, b, op, want_op;
        logic [1:0] r;
        int n, w;
        bit to;
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            r = 2'($urandom_range(1, 3));
            bus.op0 = a;
            bus.op1 = b;
            bus.req = r;
            w = exp_winner(r);
            want_op = (w == 1) ? b : a;
            run_core(int'($urandom_range(1, 12)), op, n, to);
            bus.req = 2'b00;
            checks++;
            if (to || n != 1 || op !== want_op || bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'(w)
                || bus.rsp_root !== isqrt(int'(want_op)) || bus.rsp_err !== 1'b0)
                begin errors++; $display("FAIL rand_%0d: to=%0d starts=%0d op=%0d vld=%b id=%b root=%0d err=%b, want op=%0d id=%0d root=%0d",
                    i, to, n, op, bus.rsp_valid, bus.rsp_id, bus.rsp_root, bus.rsp_err, want_op, w, isqrt(int'(want_op))); end
            last_served = w;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            accept();
        end
    endtask

    initial begin
        bus.req       = 2'b00;
        bus.op0       = '0;
        bus.op1       = '0;
        bus.core_done = 1'b0;
        bus.core_root = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_hold_stable();
        test_reset_mid_run();
        test_ignore_done();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
